iir_filter_mc: RTL and testbench

IIR_FILTER_MC -- requirements
Module: iir_filter_mc

---
 rtl/iir_mc_pkg.sv | 31 +++
 rtl/iir_mc_dp.sv | 44 ++++
 rtl/iir_filter_mc.sv | 97 +++++++++
 tb/tb_iir_filter_mc.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_mc_pkg.sv
// Shared constants and the saturation helper for the multi-channel biquad.
package iir_mc_pkg;

    localparam int NB_DEF  = 12;
    localparam int NCH_DEF = 4;

    // Field positions (in units of NB bits) inside the packed coefficient ports.
    localparam int B0_IDX = 0;
    localparam int B1_IDX = 1;
    localparam int B2_IDX = 2;
    localparam int A1_IDX = 0;
    localparam int A2_IDX = 1;

    // Widest supported NB; the helper works on a container that fits any 2NB+2 sum.
    localparam int MAX_NB = 32;
    localparam int SAT_W  = 2 * MAX_NB + 2;

    typedef logic signed [SAT_W-1:0] wide_t;

    // Clamp a sign-extended value into the signed range of an nb-bit word.
    function automatic wide_t sat_nb(input wide_t v, input int nb);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (nb - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/iir_mc_dp.sv
// Combinational datapath: feedback sum producing w, and the feed-forward
// accumulator that the output stage later shifts and saturates into y.
module iir_mc_dp
    import iir_mc_pkg::*;
#(
    parameter int NB = NB_DEF
) (
    input  logic signed [NB-1:0]     x,
    input  logic signed [NB-1:0]     w1,
    input  logic signed [NB-1:0]     w2,
    input  logic        [2*NB-1:0]   a,
    input  logic        [3*NB-1:0]   b,
    output logic signed [NB-1:0]     w,
    output logic signed [2*NB+1:0]   y_acc
);

    localparam int PW = 2 * NB;
    localparam int AW = 2 * NB + 2;

    logic signed [NB-1:0] a1, a2, b0, b1, b2;
    logic signed [PW-1:0] pa1, pa2, pb0, pb1, pb2;
    logic signed [AW-1:0] fb_sum, w_acc;

    assign a1 = a[A1_IDX*NB +: NB];
    assign a2 = a[A2_IDX*NB +: NB];
    assign b0 = b[B0_IDX*NB +: NB];
    assign b1 = b[B1_IDX*NB +: NB];
    assign b2 = b[B2_IDX*NB +: NB];

    // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        pa1    = PW'(a1) * PW'(w1);
        pa2    = PW'(a2) * PW'(w2);
        fb_sum = AW'(pa1) + AW'(pa2);
        w_acc  = AW'(x) - (fb_sum >>> (NB - 1));
        // The saturated w feeds both the y products and the stored state.
        w      = NB'(sat_nb(SAT_W'(w_acc), NB));
        pb0    = PW'(b0) * PW'(w);
        pb1    = PW'(b1) * PW'(w1);
        pb2    = PW'(b2) * PW'(w2);
        y_acc  = AW'(pb0) + AW'(pb1) + AW'(pb2);
    end

endmodule

// File: rtl/iir_filter_mc.sv
// Multi-channel second-order direct-form-II IIR filter, one sample per cycle,
// two-cycle latency, per-channel state held in a register array.
module iir_filter_mc
    import iir_mc_pkg::*;
#(
    parameter int NB  = NB_DEF,
    parameter int NCH = NCH_DEF,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              vIn,
    input  logic [NB-1:0]     dIn,
    input  logic [CW-1:0]     chIn,
    input  logic [3*NB-1:0]   b,
    input  logic [2*NB-1:0]   a,
    output logic [NB-1:0]     dOut,
    output logic [CW-1:0]     chOut,
    output logic              vOut,
    output logic              err
);

    // Sized to the full index range so chIn addresses it without width games;
    // entries at or above NCH are never written.
    localparam int DEPTH = 1 << CW;
    localparam int AW    = 2 * NB + 2;

    logic signed [NB-1:0] w1_mem [DEPTH];
    logic signed [NB-1:0] w2_mem [DEPTH];

    logic                 ch_ok;
    logic                 accept;
    logic signed [NB-1:0] w_new;
    logic signed [AW-1:0] y_acc;
    logic signed [NB-1:0] y_sat;

    logic                 s1_v;
    logic [CW-1:0]        s1_ch;
    logic signed [AW-1:0] s1_acc;

    assign ch_ok  = int'(chIn) < NCH;
    assign accept = vIn & ~clr & ch_ok;

    iir_mc_dp #(.NB(NB)) u_dp (
        .x     (dIn),
        .w1    (w1_mem[chIn]),
        .w2    (w2_mem[chIn]),
        .a     (a),
        .b     (b),
        .w     (w_new),
        .y_acc (y_acc)
    );

    assign y_sat = NB'(sat_nb(SAT_W'(s1_acc >>> (NB - 1)), NB));

    // NOTE: the state array is reset explicitly because the filter must start from zero history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                w1_mem[i] <= '0;
                w2_mem[i] <= '0;
            end
            s1_v   <= 1'b0;
            s1_ch  <= '0;
            s1_acc <= '0;
            vOut   <= 1'b0;
            dOut   <= '0;
            chOut  <= '0;
            err    <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                w1_mem[i] <= '0;
                w2_mem[i] <= '0;
            end
            s1_v <= 1'b0;
            vOut <= 1'b0;
            err  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let the read of w1 into w2 see the pre-edge value.
            s1_v <= accept;
            err  <= vIn & ~ch_ok;
            if (accept) begin
                w2_mem[chIn] <= w1_mem[chIn];
                w1_mem[chIn] <= w_new;
                s1_ch        <= chIn;
                s1_acc       <= y_acc;
            end
            vOut <= s1_v;
            if (s1_v) begin
                dOut  <= y_sat;
                chOut <= s1_ch;
            end
        end
    end

endmodule

// File: tb/tb_iir_filter_mc.sv
// Self-checking bench for iir_filter_mc: directed scenarios plus randomized
// traffic compared against an arithmetic reference model with a due-cycle queue.
module tb_iir_filter_mc;

    localparam int NB  = 12;
    localparam int NCH = 4;
    localparam int CW  = 3;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr   = 1'b0;
    logic            vIn   = 1'b0;
    logic [NB-1:0]   dIn   = '0;
    logic [CW-1:0]   chIn  = '0;
    logic [3*NB-1:0] b     = '0;
    logic [2*NB-1:0] a     = '0;
    logic [NB-1:0]   dOut;
    logic [CW-1:0]   chOut;
    logic            vOut;
    logic            err;

    iir_filter_mc #(.NB(NB), .NCH(NCH), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .vIn   (vIn),
        .dIn   (dIn),
        .chIn  (chIn),
        .b     (b),
        .a     (a),
        .dOut  (dOut),
        .chOut (chOut),
        .vOut  (vOut),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [CW-1:0] ch;
        logic [NB-1:0] d;
    } exp_t;

    exp_t          exp_q[$];
    logic [NB-1:0] obs_d[$];
    int            obs_ch[$];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int err_due = -1;

    int     cb0, cb1, cb2, ca1, ca2;
    longint mw1[NCH];
    longint mw2[NCH];

    logic [NB-1:0] last_d  = '0;
    logic [CW-1:0] last_ch = '0;

    // ---------------- reference model ----------------
    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint sat(input longint v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic logic [NB-1:0] model_step(input int ch, input int x);
        longint w, y;
        w = sat(longint'(x) - floor_div(ca1 * mw1[ch] + ca2 * mw2[ch], 2048));
        y = sat(floor_div(cb0 * w + cb1 * mw1[ch] + cb2 * mw2[ch], 2048));
        mw2[ch] = mw1[ch];
        mw1[ch] = w;
        return NB'(y);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NCH; i++) begin
            mw1[i] = 0;
            mw2[i] = 0;
        end
    endfunction

    task automatic set_coef(input int b0, input int b1, input int b2, input int a1, input int a2);
        cb0 = b0; cb1 = b1; cb2 = b2; ca1 = a1; ca2 = a2;
        b = {NB'(b2), NB'(b1), NB'(b0)};
        a = {NB'(a2), NB'(a1)};
    endtask

    // One clock of stimulus; afterwards every output is compared with the model.
    task automatic step(input bit v, input int x, input int ch, input bit c);
        exp_t e;
        @(negedge clk);
        vIn  = v;
        dIn  = NB'(x);
        chIn = CW'(ch);
        clr  = c;
        if (c) begin
            exp_q.delete();
            model_clear();
            err_due = -1;
        end else if (v && ch < NCH) begin
            exp_q.push_back('{cyc + 2, CW'(ch), model_step(ch, x)});
        end else if (v) begin
            err_due = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (vOut !== 1'b1 || dOut !== e.d || chOut !== e.ch) begin
                errors++;
                $display("FAIL output cyc=%0d got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d",
                         cyc, vOut, dOut, chOut, e.d, e.ch);
            end
            obs_d.push_back(dOut);
            obs_ch.push_back(int'(chOut));
            last_d  = e.d;
            last_ch = e.ch;
        end else begin
            checks++;
            if (vOut !== 1'b0 || dOut !== last_d || chOut !== last_ch) begin
                errors++;
                $display("FAIL idle_hold cyc=%0d got v=%b d=%h ch=%0d expected v=0 d=%h ch=%0d",
                         cyc, vOut, dOut, chOut, last_d, last_ch);
            end
        end
        checks++;
        if (err !== 1'(err_due == cyc)) begin
            errors++;
            $display("FAIL err cyc=%0d got %b expected %b", cyc, err, (err_due == cyc));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (vOut !== 1'b0 || err !== 1'b0 || dOut !== '0 || chOut !== '0) begin
            errors++;
            $display("FAIL %s got v=%b err=%b d=%h ch=%0d expected all zero",
                     tag, vOut, err, dOut, chOut);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        vIn   = 1'b0;
        clr   = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_q.delete();
        model_clear();
        err_due = -1;
        last_d  = '0;
        last_ch = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_test(input int b0, input int a1);
        set_coef(b0, 0, 0, a1, 0);
        step(1'b0, 0, 0, 1'b1);
        obs_d.delete();
        obs_ch.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_coef(0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_passthrough();
        start_test(12'h400, 0);
        step(1'b1, 12'h200, 2, 1'b0);
        idle(2);
        checks++;
        if (obs_d.size() != 1 || dOut !== 12'h100 || chOut !== 3'd2) begin
            errors++;
            $display("FAIL passthrough got n=%0d d=%h ch=%0d expected n=1 d=100 ch=2",
                     obs_d.size(), dOut, chOut);
        end
    endtask

    task automatic test_decay();
        logic [NB-1:0] want [4];
        want = '{12'h200, 12'h100, 12'h080, 12'h040};
        start_test(12'h400, -1024);
        step(1'b1, 12'h400, 1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 0, 1, 1'b0);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obs_d.size() || obs_d[i] !== want[i]) begin
                errors++;
                $display("FAIL decay[%0d] got %h expected %h", i,
                         (i < obs_d.size()) ? obs_d[i] : 12'hxxx, want[i]);
            end
        end
    endtask

    task automatic test_interleave();
        logic [NB-1:0] want [4];
        int n0, n3;
        want = '{12'h200, 12'h100, 12'h080, 12'h040};
        n0 = 0;
        n3 = 0;
        start_test(12'h400, -1024);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, (k == 0) ? 12'h400 : 0, 0, 1'b0);
            step(1'b1, 0, 3, 1'b0);
        end
        idle(2);
        for (int i = 0; i < obs_d.size(); i++) begin
            if (obs_ch[i] == 0) begin
                checks++;
                if (n0 >= 4 || obs_d[i] !== want[n0]) begin
                    errors++;
                    $display("FAIL interleave_ch0[%0d] got %h", n0, obs_d[i]);
                end
                n0++;
            end else begin
                checks++;
                if (obs_ch[i] != 3 || obs_d[i] !== 12'h000) begin
                    errors++;
                    $display("FAIL interleave_ch3 got ch=%0d d=%h expected ch=3 d=000",
                             obs_ch[i], obs_d[i]);
                end
                n3++;
            end
        end
        checks++;
        if (n0 != 4 || n3 != 4) begin
            errors++;
            $display("FAIL interleave_count got %0d/%0d expected 4/4", n0, n3);
        end
    endtask

    task automatic test_saturate();
        start_test(0, 0);
        set_coef(12'h7FF, 12'h7FF, 12'h7FF, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 12'h7FF, 0, 1'b0);
        idle(2);
        checks++;
        if (dOut !== 12'h7FF) begin
            errors++;
            $display("FAIL sat_pos got %h expected 7ff", dOut);
        end
        for (int i = 0; i < 4; i++) step(1'b1, -2048, 0, 1'b0);
        idle(2);
        checks++;
        if (dOut !== 12'h800) begin
            errors++;
            $display("FAIL sat_neg got %h expected 800", dOut);
        end
    endtask

    task automatic test_bad_channel();
        logic [NB-1:0] want [3];
        want = '{12'h200, 12'h100, 12'h080};
        start_test(12'h400, -1024);
        step(1'b1, 12'h400, 1, 1'b0);
        step(1'b1, 12'h3FF, 5, 1'b0);
        step(1'b1, 0, 1, 1'b0);
        step(1'b1, 12'h123, 7, 1'b0);
        step(1'b1, 0, 1, 1'b0);
        idle(2);
        checks++;
        if (obs_d.size() != 3) begin
            errors++;
            $display("FAIL bad_ch_count got %0d expected 3", obs_d.size());
        end
        for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== want[i] || obs_ch[i] != 1) begin
                errors++;
                $display("FAIL bad_ch_decay[%0d] got d=%h ch=%0d expected d=%h ch=1",
                         i, obs_d[i], obs_ch[i], want[i]);
            end
        end
    endtask

    task automatic test_clear_and_reset();
        start_test(12'h400, -1024);
        step(1'b1, 12'h400, 1, 1'b0);
        step(1'b1, 0, 1, 1'b0);
        step(1'b1, 0, 1, 1'b0);
        idle(2);
        step(1'b1, 0, 1, 1'b1);
        idle(2);
        step(1'b1, 12'h400, 1, 1'b0);
        idle(2);
        checks++;
        if (obs_d.size() != 4 || dOut !== 12'h200) begin
            errors++;
            $display("FAIL clr_restart got n=%0d d=%h expected n=4 d=200", obs_d.size(), dOut);
        end
        // Reset with one output showing and one sample still in flight.
        step(1'b1, 12'h400, 1, 1'b0);
        step(1'b1, 0, 1, 1'b0);
        apply_reset();
        idle(3);
        obs_d.delete();
        step(1'b1, 12'h400, 1, 1'b0);
        idle(2);
        checks++;
        if (obs_d.size() != 1 || dOut !== 12'h200) begin
            errors++;
            $display("FAIL rst_restart got n=%0d d=%h expected n=1 d=200", obs_d.size(), dOut);
        end
    endtask

    task automatic test_random();
        int ch;
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0 || $urandom_range(0, 19) == 0) begin
                set_coef(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                         int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 2047)) - 1024,
                         int'($urandom_range(0, 1023)) - 512);
            end
            if (i == 200) apply_reset();
            ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)) - 2048, ch,
                 $urandom_range(0, 39) == 0);
        end
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_decay();
        test_interleave();
        test_saturate();
        test_bad_channel();
        test_clear_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
